// File: rtl/ecc_pkg.sv
// Shared types and constants for the ECC scalar-multiply sequencer.
package ecc_pkg;

  localparam int unsigned K_WIDTH_DEF = 4;
  localparam int unsigned COORD_W_DEF = 32;

  localparam logic OP_DBL = 1'b0;
  localparam logic OP_ADD = 1'b1;

  typedef enum logic [2:0] {
    StIdle,
    StScan,
    StDblReq,
    StDblWait,
    StAddReq,
    StAddWait,
    StDone
  } state_e;

  function automatic int unsigned idx_w(input int unsigned w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/ecc_lead_one.sv
// Combinational leading-one detector: index of the most significant set bit plus a zero flag.
module ecc_lead_one
  import ecc_pkg::*;
#(
  parameter int unsigned K_WIDTH = K_WIDTH_DEF,
  localparam int unsigned IDX_W  = idx_w(K_WIDTH)
) (
  input  logic [K_WIDTH-1:0] i_k,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_zero
);

  always_comb begin
    o_idx  = '0;
    o_zero = ~|i_k;
    for (int unsigned i = 0; i < K_WIDTH; i++) begin
      if (i_k[i]) o_idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/ecc_smul_ctrl.sv
// Left-to-right double-and-add sequencer for kP driving a shared point-arithmetic unit.
// Optional build macro ECC_SMUL_CONST_TIME_EN issues an ADD for every scanned bit.
module ecc_smul_ctrl
  import ecc_pkg::*;
#(
  parameter int unsigned K_WIDTH = K_WIDTH_DEF,
  parameter int unsigned COORD_W = COORD_W_DEF
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_start,
  input  logic [K_WIDTH-1:0] i_k,
  input  logic [COORD_W-1:0] i_a,
  input  logic [COORD_W-1:0] i_prime,
  input  logic [COORD_W-1:0] i_px,
  input  logic [COORD_W-1:0] i_py,
  output logic [COORD_W-1:0] o_a,
  output logic [COORD_W-1:0] o_prime,
  output logic               o_op_valid,
  output logic               o_op_sel,
  output logic [COORD_W-1:0] o_op_x1,
  output logic [COORD_W-1:0] o_op_y1,
  output logic [COORD_W-1:0] o_op_x2,
  output logic [COORD_W-1:0] o_op_y2,
  input  logic               i_op_ready,
  input  logic               i_res_valid,
  input  logic [COORD_W-1:0] i_res_x,
  input  logic [COORD_W-1:0] i_res_y,
  input  logic               i_res_inf,
  output logic               o_busy,
  output logic               o_done,
  output logic [COORD_W-1:0] o_kpx,
  output logic [COORD_W-1:0] o_kpy,
  output logic               o_inf
);

  localparam int unsigned IDX_W = idx_w(K_WIDTH);

  state_e             r_state;
  logic [K_WIDTH-1:0] r_k;
  logic [COORD_W-1:0] r_px, r_py, r_a, r_prime;
  logic [COORD_W-1:0] r_rx, r_ry;
  logic               r_rinf;
  logic [IDX_W-1:0]   r_idx;
  logic               r_op_valid, r_op_sel;
  logic [COORD_W-1:0] r_op_x1, r_op_y1, r_op_x2, r_op_y2;
  logic               r_busy, r_done, r_inf;
  logic [COORD_W-1:0] r_kpx, r_kpy;

  logic [IDX_W-1:0]   w_lo_idx;
  logic               w_lo_zero;
  logic               w_bit, w_add_need;
  state_e             w_after_add, w_after_dbl, w_step_nxt;
  logic [IDX_W-1:0]   w_after_add_idx, w_after_dbl_idx, w_idx_nxt;
  logic               w_step;
  logic [COORD_W-1:0] w_nr_x, w_nr_y;
  logic               w_nr_inf;

  ecc_lead_one #(
    .K_WIDTH (K_WIDTH)
  ) u_lead_one (
    .i_k    (r_k),
    .o_idx  (w_lo_idx),
    .o_zero (w_lo_zero)
  );

  assign w_bit = r_k[r_idx];
`ifdef ECC_SMUL_CONST_TIME_EN
  assign w_add_need = 1'b1;
`else
  assign w_add_need = w_bit;
`endif

  // w_step marks a cycle that finishes a scan/op step; w_nr_* is R after that step.
  always_comb begin
    w_after_add     = StDblReq;
    w_after_add_idx = r_idx - 1'b1;
    if (r_idx == '0) begin
      w_after_add     = StDone;
      w_after_add_idx = r_idx;
    end
    w_after_dbl     = w_add_need ? StAddReq : w_after_add;
    w_after_dbl_idx = w_add_need ? r_idx : w_after_add_idx;

    w_step     = 1'b0;
    w_step_nxt = r_state;
    w_idx_nxt  = r_idx;
    w_nr_x     = r_rx;
    w_nr_y     = r_ry;
    w_nr_inf   = r_rinf;
    case (r_state)
      StScan: begin
        w_step = 1'b1;
        if (w_lo_zero) begin
          w_nr_x     = '0;
          w_nr_y     = '0;
          w_nr_inf   = 1'b1;
          w_step_nxt = StDone;
        end else begin
          w_nr_x   = r_px;
          w_nr_y   = r_py;
          w_nr_inf = 1'b0;
          if (w_lo_idx == '0) begin
            w_step_nxt = StDone;
          end else begin
            w_step_nxt = StDblReq;
            w_idx_nxt  = w_lo_idx - 1'b1;
          end
        end
      end
      StDblReq: begin
        if (r_rinf) begin
          w_step     = 1'b1;
          w_step_nxt = w_after_dbl;
          w_idx_nxt  = w_after_dbl_idx;
        end
      end
      StDblWait: begin
        if (i_res_valid) begin
          w_step     = 1'b1;
          w_nr_x     = i_res_x;
          w_nr_y     = i_res_y;
          w_nr_inf   = i_res_inf;
          w_step_nxt = w_after_dbl;
          w_idx_nxt  = w_after_dbl_idx;
        end
      end
      StAddReq: begin
        if (r_rinf) begin
          w_step = 1'b1;
          if (w_bit) begin
            w_nr_x   = r_px;
            w_nr_y   = r_py;
            w_nr_inf = 1'b0;
          end
          w_step_nxt = w_after_add;
          w_idx_nxt  = w_after_add_idx;
        end
      end
      StAddWait: begin
        if (i_res_valid) begin
          w_step = 1'b1;
          // A cleared bit only happens in constant-time mode: discard the dummy sum.
          if (w_bit) begin
            w_nr_x   = i_res_x;
            w_nr_y   = i_res_y;
            w_nr_inf = i_res_inf;
          end
          w_step_nxt = w_after_add;
          w_idx_nxt  = w_after_add_idx;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= StIdle;
      r_k        <= '0;
      r_px       <= '0;
      r_py       <= '0;
      r_a        <= '0;
      r_prime    <= '0;
      r_rx       <= '0;
      r_ry       <= '0;
      r_rinf     <= 1'b0;
      r_idx      <= '0;
      r_op_valid <= 1'b0;
      r_op_sel   <= OP_DBL;
      r_op_x1    <= '0;
      r_op_y1    <= '0;
      r_op_x2    <= '0;
      r_op_y2    <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_kpx      <= '0;
      r_kpy      <= '0;
      r_inf      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        StIdle: begin
          if (i_start) begin
            r_k     <= i_k;
            r_px    <= i_px;
            r_py    <= i_py;
            r_a     <= i_a;
            r_prime <= i_prime;
            r_busy  <= 1'b1;
            r_state <= StScan;
          end
        end
        StDblReq: begin
          if (r_op_valid && i_op_ready) begin
            r_op_valid <= 1'b0;
            r_state    <= StDblWait;
          end
        end
        StAddReq: begin
          if (r_op_valid && i_op_ready) begin
            r_op_valid <= 1'b0;
            r_state    <= StAddWait;
          end
        end
        StDone: begin
          r_busy  <= 1'b0;
          r_state <= StIdle;
        end
        default: ;
      endcase

      if (w_step) begin
        r_state <= w_step_nxt;
        r_idx   <= w_idx_nxt;
        r_rx    <= w_nr_x;
        r_ry    <= w_nr_y;
        r_rinf  <= w_nr_inf;
        case (w_step_nxt)
          StDblReq: begin
            r_op_valid <= ~w_nr_inf;
            r_op_sel   <= OP_DBL;
            r_op_x1    <= w_nr_x;
            r_op_y1    <= w_nr_y;
          end
          StAddReq: begin
            r_op_valid <= ~w_nr_inf;
            r_op_sel   <= OP_ADD;
            r_op_x1    <= w_nr_x;
            r_op_y1    <= w_nr_y;
            r_op_x2    <= r_px;
            r_op_y2    <= r_py;
          end
          StDone: begin
            r_done <= 1'b1;
            r_kpx  <= w_nr_inf ? '0 : w_nr_x;
            r_kpy  <= w_nr_inf ? '0 : w_nr_y;
            r_inf  <= w_nr_inf;
          end
          default: ;
        endcase
      end
    end
  end

  assign o_a        = r_a;
  assign o_prime    = r_prime;
  assign o_op_valid = r_op_valid;
  assign o_op_sel   = r_op_sel;
  assign o_op_x1    = r_op_x1;
  assign o_op_y1    = r_op_y1;
  assign o_op_x2    = r_op_x2;
  assign o_op_y2    = r_op_y2;
  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_kpx      = r_kpx;
  assign o_kpy      = r_kpy;
  assign o_inf      = r_inf;

endmodule
